// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables and mux selects from the current state. A
// mem_ready handshake stalls FETCH, MEMRD and MEMWR. The block also counts
// retired instructions and flags unknown opcodes in DECODE.
module multicycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               link,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JAL    = 4'd12,
    S_RST    = 4'd15
  } state_t;

  // Per-state control word; held in a register alongside the state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t             state_reg;
  state_t             state_next;
  ctl_t               ctl_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               retire;
  logic               known_op;

  // Control word for a given state; anything not set stays 0.
  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        // ir_write/pc_write are further gated by mem_ready at the output.
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.reg_write = 1'b1;
        c.link      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection, opcode legality and retire detection.
  always_comb begin
    state_next = S_FETCH;
    known_op   = 1'b1;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_JAL:       state_next = S_JAL;
          default: begin
            known_op   = 1'b0;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_next = mem_ready ? S_FETCH : S_MEMWR;
        retire     = mem_ready;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB, S_JAL: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default:  state_next = S_FETCH;
    endcase
  end

  // State, registered control word and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_RST;
      ctl_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctl_reg   <= ctl_for(state_next);
      if (retire) begin
        count_reg <= count_reg + COUNT_W'(1);
      end
    end
  end

  // FETCH only latches IR and advances PC once memory delivers the word.
  assign pc_write      = ctl_reg.pc_write & (mem_ready | (state_reg != S_FETCH));
  assign ir_write      = ctl_reg.ir_write & mem_ready;
  assign pc_write_cond = ctl_reg.pc_write_cond;
  assign iord          = ctl_reg.iord;
  assign mem_read      = ctl_reg.mem_read;
  assign mem_write     = ctl_reg.mem_write;
  assign reg_dst       = ctl_reg.reg_dst;
  assign mem_to_reg    = ctl_reg.mem_to_reg;
  assign reg_write     = ctl_reg.reg_write;
  assign link          = ctl_reg.link;
  assign alu_src_a     = ctl_reg.alu_src_a;
  assign alu_src_b     = ctl_reg.alu_src_b;
  assign alu_op        = ctl_reg.alu_op;
  assign pc_source     = ctl_reg.pc_source;
  assign state         = state_reg;
  assign illegal_op    = (state_reg == S_DECODE) && !known_op;
  assign retired_count = count_reg;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style sequencer for a multi-cycle variant of the single-cycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and asserts the per-state datapath enables: PC write, IR write, memory access, register write and mux selects. It supports a memory-ready handshake so a slow unified memory can stall the machine. It also keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
COUNT_W, 16, width of retired-instruction counter (wraps modulo 2^COUNT_W)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears state and counter
opcode  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  latch instruction register
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
link  out  1  jal: write PC to $31 (overrides reg_dst/mem_to_reg)
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 1, 10=signext imm, 11=signext imm (branch offset)
alu_op  out  2  00=add, 01=sub, 10=funct-decoded; drives alucontrol
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  4  current state encoding (debug)
illegal_op  out  1  1-cycle pulse in DECODE on unknown opcode
retired_count  out  COUNT_W  instructions completed

Behaviour:
- State register updates on posedge clk. Async reset forces state RST (15) and retired_count=0.
- RST: all outputs 0. Unconditionally goes to FETCH on the next clk.
- Outputs decode from state only, except FETCH gating. Every output not listed for a state is 0.
- FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready=1.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - 000011 -> JAL
  - else illegal_op=1, -> FETCH, no retire.
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): iord=1, mem_read=1. Holds until mem_ready, then -> MEMWB.
- MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR(5): iord=1, mem_write=1, held high while waiting. Write commits on the mem_ready cycle; then -> FETCH.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB(7): reg_dst=1, reg_write=1 -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP(9): pc_write=1, pc_source=10 -> FETCH.
- ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB(11): reg_dst=0, reg_write=1 -> FETCH.
- JAL(12): pc_write=1, pc_source=10, reg_write=1, link=1 -> FETCH.
- Encodings 13, 14: unreachable; treat as RST (outputs 0, -> FETCH).
- Retire rule: retired_count increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, JUMP, ADDIWB or JAL. It wraps from all-ones to 0.
- Latency with mem_ready tied 1:
  - R-type, addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq, j, jal: 3 cycles
- Each wait cycle on mem_ready adds exactly one cycle. Outputs stay constant during the wait, except ir_write and pc_write in FETCH, which remain 0 until ready.
- Reset asserted mid-instruction: state goes to RST immediately (asynchronously) and outputs drop to 0 in the same cycle. No partial write strobes survive.
- The opcode input is ignored outside DECODE and MEMADR.

Test Plan:
1. Reset pulse mid-EXEC, then release, mem_ready=1 -> state=15 with all outputs 0 during reset; FETCH on the first edge after release; retired_count=0.
2. R-type (opcode 000000), mem_ready=1 -> state sequence 0,1,6,7,0; reg_dst=1 and reg_write=1 only in state 7; retired_count 0->1.
3. lw (100011) with mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; mem_read and iord stay 1 for 3 cycles; reg_write with mem_to_reg=1 in state 4.
4. sw (101011) with mem_ready low 1 cycle in FETCH -> ir_write=0 on the first FETCH cycle, 1 on the second; mem_write=1 in state 5; total 5 cycles.
5. beq, j, jal in sequence -> each takes 3 cycles; pc_write_cond=1 with pc_source=01 for beq; pc_write=1 with pc_source=10 for j; jal additionally has link=1 and reg_write=1; retired_count +3.
6. opcode 111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, retired_count unchanged. Preload the counter to 16'hFFFF and retire one instruction -> counter reads 0.
